// File: rtl/prbs4_checker.sv
// Self-check for the 4-bit XNOR LFSR generator: lock/unlock FSM, saturating error count, lockup flag.
// Optional sequence-period check is compiled in with `define PRBS4_PERIOD_CHECK_EN.
module prbs4_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       din,
  input  logic             clr,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             lockup,
  output logic             period_err
);

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  state_t           state_q;
  logic [3:0]       prev_q;
  logic [3:0]       match_cnt_q;
  logic [3:0]       miss_cnt_q;
  logic             locked_q;
  logic             mismatch_q;
  logic             lockup_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [3:0] pred;
  logic [3:0] match_cnt_d;
  logic [3:0] miss_cnt_d;
  logic       hit;
  logic       all_ones;
  logic       unlock_now;
  logic       err_inc;

  assign pred        = {prev_q[2:0], ~(prev_q[3] ^ prev_q[2])};
  assign hit         = (din == pred);
  assign all_ones    = (din == 4'b1111);
  assign match_cnt_d = match_cnt_q + 4'd1;
  assign miss_cnt_d  = miss_cnt_q + 4'd1;
  assign unlock_now  = en && (state_q == LOCKED) && !hit && (miss_cnt_d == 4'(UNLOCK_CNT));
  assign err_inc     = en && (state_q == LOCKED) && !hit && (err_cnt_q != '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= 4'd0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      if (en) begin
        prev_q <= din;
        case (state_q)
          IDLE: state_q <= SEARCH;
          SEARCH: begin
            if (!hit) begin
              match_cnt_q <= 4'd0;
              mismatch_q  <= 1'b1;
            end else if (all_ones) begin
              // 1111 predicts itself; never let a stuck generator lock
              match_cnt_q <= 4'd0;
            end else if (match_cnt_d == 4'(LOCK_CNT)) begin
              state_q     <= LOCKED;
              locked_q    <= 1'b1;
              match_cnt_q <= 4'd0;
              miss_cnt_q  <= 4'd0;
            end else begin
              match_cnt_q <= match_cnt_d;
            end
          end
          LOCKED: begin
            if (hit) begin
              miss_cnt_q <= 4'd0;
            end else begin
              mismatch_q <= 1'b1;
              if (unlock_now) begin
                state_q     <= SEARCH;
                locked_q    <= 1'b0;
                match_cnt_q <= 4'd0;
                miss_cnt_q  <= 4'd0;
              end else begin
                miss_cnt_q <= miss_cnt_d;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      lockup_q  <= 1'b0;
    end else if (clr) begin
      err_cnt_q <= '0;
      lockup_q  <= 1'b0;
    end else begin
      if (err_inc) err_cnt_q <= err_cnt_q + 1'b1;
      if (en && all_ones && (prev_q == 4'b1111)) lockup_q <= 1'b1;
    end
  end

  assign locked   = locked_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
  assign lockup   = lockup_q;

`ifdef PRBS4_PERIOD_CHECK_EN
  logic [4:0] period_cnt_q;
  logic       seen_zero_q;
  logic       period_err_q;

  // Count samples between 0000 words; a clean sequence revisits 0000 every 15 samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_q <= 5'd0;
      seen_zero_q  <= 1'b0;
      period_err_q <= 1'b0;
    end else begin
      period_err_q <= 1'b0;
      if (en && (state_q == LOCKED)) begin
        if (unlock_now) begin
          period_cnt_q <= 5'd0;
          seen_zero_q  <= 1'b0;
        end else if (din == 4'b0000) begin
          if (seen_zero_q && (period_cnt_q != 5'd15)) period_err_q <= 1'b1;
          period_cnt_q <= 5'd1;
          seen_zero_q  <= 1'b1;
        end else if (period_cnt_q != 5'h1f) begin
          period_cnt_q <= period_cnt_q + 5'd1;
        end
      end
    end
  end

  assign period_err = period_err_q;
`else
  assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_prbs4_checker.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Instance a: defaults; instance b: ERR_W=2, UNLOCK_CNT=15 for saturation.
module tb_prbs4_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_en, a_clr, a_locked, a_mm, a_lu, a_pe;
  logic [3:0]  a_din;
  logic [15:0] a_err;
  logic        b_rst, b_en, b_clr, b_locked, b_mm, b_lu, b_pe;
  logic [3:0]  b_din;
  logic [1:0]  b_err;

  prbs4_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .din(a_din), .clr(a_clr),
    .locked(a_locked), .mismatch(a_mm), .err_cnt(a_err), .lockup(a_lu), .period_err(a_pe)
  );

  prbs4_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .ERR_W(2)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .din(b_din), .clr(b_clr),
    .locked(b_locked), .mismatch(b_mm), .err_cnt(b_err), .lockup(b_lu), .period_err(b_pe)
  );

  typedef struct {
    bit    sel;
    bit    lk;
    bit    mm;
    int    err;
    bit    lu;
    bit    pe;
    bit    chkpe;
    string tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_x;
  int         total = 0;
  int         pass  = 0;
  bit         pe_on;
  string      tag;
  logic [3:0] g;

  function automatic void chk(input string nm, input int got, input int want);
    total++;
    if (got == want) pass++;
    else $display("FAIL %s got=%0d want=%0d", nm, got, want);
  endfunction

  // Reference generator (the producer the checker listens to)
  function automatic logic [3:0] gen_next(input logic [3:0] q);
    return {q[2:0], ~(q[3] ^ q[2])};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_x = sb.pop_front();
      if (!mon_x.sel) begin
        chk({mon_x.tag, ".a.locked"},   a_locked, mon_x.lk);
        chk({mon_x.tag, ".a.mismatch"}, a_mm,     mon_x.mm);
        chk({mon_x.tag, ".a.err_cnt"},  a_err,    mon_x.err);
        chk({mon_x.tag, ".a.lockup"},   a_lu,     mon_x.lu);
        if (mon_x.chkpe) chk({mon_x.tag, ".a.period_err"}, a_pe, mon_x.pe);
      end else begin
        chk({mon_x.tag, ".b.locked"},   b_locked, mon_x.lk);
        chk({mon_x.tag, ".b.mismatch"}, b_mm,     mon_x.mm);
        chk({mon_x.tag, ".b.err_cnt"},  b_err,    mon_x.err);
        chk({mon_x.tag, ".b.lockup"},   b_lu,     mon_x.lu);
        if (mon_x.chkpe) chk({mon_x.tag, ".b.period_err"}, b_pe, mon_x.pe);
      end
    end
  end

  task automatic send(input bit sel, input logic [3:0] d, input bit e, input bit c,
                      input bit lk, input bit mm, input int err, input bit lu, input bit pe);
    exp_t x;
    if (!sel) begin
      a_en = e; a_din = d; a_clr = c; b_en = 1'b0; b_clr = 1'b0;
    end else begin
      b_en = e; b_din = d; b_clr = c; a_en = 1'b0; a_clr = 1'b0;
    end
    @(posedge clk);
    x.sel = sel; x.lk = lk; x.mm = mm; x.err = err; x.lu = lu;
    x.pe = pe; x.chkpe = pe_on; x.tag = tag;
    sb.push_back(x);
    #1;
  endtask

  task automatic run_clean(input bit sel, input int n, input bit lk, input int err, input bit lu);
    repeat (n) begin
      send(sel, g, 1'b1, 1'b0, lk, 1'b0, err, lu, 1'b0);
      g = gen_next(g);
    end
  endtask

  // Async reset between edges; outputs must drop before any clock edge
  task automatic async_reset(input bit sel);
    @(negedge clk);
    #1;
    a_en = 1'b0; b_en = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
    if (!sel) a_rst = 1'b1; else b_rst = 1'b1;
    #1;
    if (!sel) begin
      chk({tag, ".rst.a.locked"}, a_locked, 0);
      chk({tag, ".rst.a.mismatch"}, a_mm, 0);
      chk({tag, ".rst.a.err_cnt"}, a_err, 0);
      chk({tag, ".rst.a.lockup"}, a_lu, 0);
      chk({tag, ".rst.a.period_err"}, a_pe, 0);
    end else begin
      chk({tag, ".rst.b.locked"}, b_locked, 0);
      chk({tag, ".rst.b.mismatch"}, b_mm, 0);
      chk({tag, ".rst.b.err_cnt"}, b_err, 0);
      chk({tag, ".rst.b.lockup"}, b_lu, 0);
    end
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
  endtask

  initial begin
`ifdef PRBS4_PERIOD_CHECK_EN
    pe_on = 1'b0;
`else
    pe_on = 1'b1;
`endif
    a_rst = 1'b1; b_rst = 1'b1;
    a_en = 1'b0; b_en = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
    a_din = 4'd0; b_din = 4'd0;
    #3;
    tag = "reset";
    chk("reset.a.locked", a_locked, 0);
    chk("reset.a.mismatch", a_mm, 0);
    chk("reset.a.err_cnt", a_err, 0);
    chk("reset.a.lockup", a_lu, 0);
    chk("reset.b.err_cnt", b_err, 0);
    @(negedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;

    // Clean sequence: lock on the 4th match (sample 1110)
    tag = "lock";
    g = 4'b0000;
    for (int k = 0; k < 100; k++) begin
      send(1'b0, g, 1'b1, 1'b0, (k >= 4), 1'b0, 0, 1'b0, 1'b0);
      g = gen_next(g);
    end

    // One corrupted word disturbs two predictions; stays locked
    tag = "single";
    while (g != 4'b1011) begin
      send(1'b0, g, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      g = gen_next(g);
    end
    send(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    g = gen_next(4'b1011);
    send(1'b0, g, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    g = gen_next(g);
    run_clean(1'b0, 6, 1'b1, 2, 1'b0);
    tag = "hold";
    send(1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    send(1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0);

    // Three consecutive misses unlock; generator restarted from 0000 relocks after 4 matches
    tag = "unlock";
    send(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    send(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    send(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    g = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      send(1'b0, g, 1'b1, 1'b0, (k == 4), 1'b0, 5, 1'b0, 1'b0);
      g = gen_next(g);
    end

    // clr wins over a same-edge error increment
    tag = "clr";
    run_clean(1'b0, 2, 1'b1, 5, 1'b0);
    send(1'b0, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    g = gen_next(4'b0101);
    send(1'b0, g, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    send(1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    g = gen_next(4'b0011);
    send(1'b0, g, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0);

    // Stuck-at-1111 generator
    tag = "lockup";
    async_reset(1'b0);
    send(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++)
      send(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    send(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    send(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Saturation on the narrow instance, then reset mid-stream
    tag = "sat";
    g = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      send(1'b1, g, 1'b1, 1'b0, (k == 4), 1'b0, 0, 1'b0, 1'b0);
      g = gen_next(g);
    end
    for (int i = 1; i <= 6; i++)
      send(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, (i < 3) ? i : 3, 1'b0, 1'b0);
    async_reset(1'b1);
    send(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    send(1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);

`ifdef PRBS4_PERIOD_CHECK_EN
    tag = "period";
    pe_on = 1'b1;
    async_reset(1'b0);
    g = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      send(1'b0, g, 1'b1, 1'b0, (k >= 4), 1'b0, 0, 1'b0, 1'b0);
      g = gen_next(g);
    end
    run_clean(1'b0, 10, 1'b1, 0, 1'b0);
    run_clean(1'b0, 15, 1'b1, 0, 1'b0);
    run_clean(1'b0, 2, 1'b1, 0, 1'b0);
    g = gen_next(g);
    send(1'b0, g, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    g = gen_next(g);
    run_clean(1'b0, 11, 1'b1, 1, 1'b0);
    send(1'b0, g, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1);
    g = gen_next(g);
    run_clean(1'b0, 14, 1'b1, 1, 1'b0);
    send(1'b0, g, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0);
`endif

    a_en = 1'b0; b_en = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain.queue_left", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
